// File: rtl/layer_sequencer_if.sv
// Handshake bundle between the layer sequencer and its sample source, layer engines and result consumer.
interface layer_sequencer_if #(
  parameter int LAYERS = 3,
  parameter int CNTW   = 8
);
  logic              start_valid;
  logic              start_ready;
  logic              load_in;
  logic [LAYERS-1:0] layer_start;
  logic [LAYERS-1:0] layer_done;
  logic [2:0]        cur_layer;
  logic              busy;
  logic              result_valid;
  logic              result_ready;
  logic              error;
  logic              clear_err;
  logic [CNTW-1:0]   sample_count;

  // Environment side: sample source, layer engines, result consumer.
  modport master (
    output start_valid, layer_done, result_ready, clear_err,
    input  start_ready, load_in, layer_start, cur_layer, busy,
           result_valid, error, sample_count
  );

  // Sequencer side.
  modport slave (
    input  start_valid, layer_done, result_ready, clear_err,
    output start_ready, load_in, layer_start, cur_layer, busy,
           result_valid, error, sample_count
  );
endinterface

// File: rtl/layer_sequencer.sv
// Steps one input sample through LAYERS compute layers in order, with a per-layer
// completion timeout, a result handshake and a wrapping completed-sample counter.
//
// state | meaning
// IDLE  | ready for a new sample
// LOAD  | one cycle: input bus captured into the first-layer register
// START | one cycle: launch layer cur_layer
// WAIT  | awaiting layer_done[cur_layer], timer running
// DONE  | result held valid until the consumer takes it
// ERR   | layer timed out, held until clear_err
module layer_sequencer #(
  parameter int LAYERS  = 3,
  parameter int TIMEOUT = 1024,
  parameter int CNTW    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  layer_sequencer_if.slave  bus
);

  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      cur_layer_q, cur_layer_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [CNTW-1:0] count_q, count_d;

  // Padded to 8 so a 3-bit layer index always selects in range.
  logic [7:0] done_pad;
  logic [7:0] start_pad;
  logic       done_sel;
  logic       last_layer;

  assign done_pad   = 8'(bus.layer_done);
  assign done_sel   = done_pad[cur_layer_q];
  assign start_pad  = 8'd1 << cur_layer_q;
  assign last_layer = (cur_layer_q == 3'(LAYERS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cur_layer_q <= '0;
      timer_q     <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      cur_layer_q <= cur_layer_d;
      timer_q     <= timer_d;
      count_q     <= count_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cur_layer_d = cur_layer_q;
    timer_d     = timer_q;
    count_d     = count_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start_valid) begin
          state_d     = S_LOAD;
          cur_layer_d = '0;
        end
      end
      S_LOAD:  state_d = S_START;
      S_START: begin
        state_d = S_WAIT;
        timer_d = '0;
      end
      S_WAIT: begin
        // A done arriving on the timeout cycle still counts as success.
        if (done_sel) begin
          if (last_layer) begin
            state_d = S_DONE;
            count_d = count_q + 1'b1;
          end else begin
            state_d     = S_START;
            cur_layer_d = cur_layer_q + 3'd1;
          end
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          state_d = S_ERR;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_DONE: if (bus.result_ready) state_d = S_IDLE;
      S_ERR:  if (bus.clear_err)    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.start_ready  = 1'b0;
    bus.load_in      = 1'b0;
    bus.layer_start  = '0;
    bus.busy         = 1'b1;
    bus.result_valid = 1'b0;
    bus.error        = 1'b0;
    case (state_q)
      S_IDLE: begin
        bus.start_ready = 1'b1;
        bus.busy        = 1'b0;
      end
      S_LOAD:  bus.load_in      = 1'b1;
      S_START: bus.layer_start  = start_pad[LAYERS-1:0];
      S_DONE:  bus.result_valid = 1'b1;
      S_ERR:   bus.error        = 1'b1;
      default: ;
    endcase
  end

  assign bus.cur_layer    = cur_layer_q;
  assign bus.sample_count = count_q;

endmodule

// File: tb/tb_layer_sequencer.sv
// Randomized bench for layer_sequencer: each sample's full cycle-by-cycle output
// trace is predicted from a schedule computed arithmetically from the per-layer done delays.
module tb_layer_sequencer;
  localparam int LAYERS  = 3;
  localparam int TIMEOUT = 16;
  localparam int CNTW    = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  layer_sequencer_if #(.LAYERS(LAYERS), .CNTW(CNTW)) bus ();

  layer_sequencer #(.LAYERS(LAYERS), .TIMEOUT(TIMEOUT), .CNTW(CNTW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;
  logic [CNTW-1:0] cnt_m;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] pack(input logic ld, input logic [LAYERS-1:0] ls,
                                       input logic [2:0] cl, input logic bsy, input logic rv,
                                       input logic er, input logic sr, input logic [CNTW-1:0] cnt);
    return 32'({ld, ls, cl, bsy, rv, er, sr, cnt});
  endfunction

  function automatic logic [31:0] obs(input bit with_cur);
    return pack(bus.load_in, bus.layer_start, with_cur ? bus.cur_layer : 3'd0, bus.busy,
                bus.result_valid, bus.error, bus.start_ready, bus.sample_count);
  endfunction

  // Sample n is taken 1 time unit after the n-th edge following the accepting edge
  // (load_in is expected at n=1). Layer i starts at st[i] = 2 + sum_{j<i}(d[j]+1); its
  // done is driven after sample st[i]+d[i]. A layer with d > TIMEOUT times out, with
  // error visible TIMEOUT+1 samples after its start. rst_at>0 pulses reset at that sample.
  task automatic run_sample(input int d[LAYERS], input bit noise, input int hold, input int rst_at);
    int st[LAYERS];
    int we[LAYERS];
    int f, last, end_n, rel, acc, cur_e;
    logic [LAYERS-1:0] ls_e, dn;
    logic [CNTW-1:0] cnt_e;
    logic fin;
    f = -1;
    acc = 2;
    for (int i = 0; i < LAYERS; i++) begin
      st[i] = 0;
      we[i] = 0;
    end
    for (int i = 0; i < LAYERS; i++) begin
      st[i] = acc;
      if (d[i] > TIMEOUT) begin
        f = i;
        break;
      end
      acc += d[i] + 1;
    end
    last  = (f < 0) ? LAYERS - 1 : f;
    end_n = (f < 0) ? acc : st[f] + 1 + TIMEOUT;
    for (int i = 0; i <= last; i++) we[i] = (i == f) ? end_n - 1 : st[i] + d[i];
    rel = end_n + hold;

    bus.start_valid = 1'b1;
    for (int n = 1; n <= rel + 1; n++) begin
      @(posedge clk);
      #1;
      bus.start_valid  = 1'b0;
      bus.result_ready = 1'b0;
      bus.clear_err    = 1'b0;
      if (n == rel + 1) begin
        if (f < 0) cnt_m = cnt_m + 1'b1;
        check_eq("release_idle", obs(0), pack(1'b0, '0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, cnt_m));
        bus.layer_done = '0;
        break;
      end
      fin   = (n >= end_n);
      ls_e  = '0;
      cur_e = 0;
      for (int i = 0; i <= last; i++) begin
        if (n == st[i]) ls_e[i] = 1'b1;
        if (n >= st[i]) cur_e = i;
      end
      cnt_e = cnt_m + ((f < 0 && fin) ? CNTW'(1) : CNTW'(0));
      check_eq("cycle", obs(1), pack(n == 1, ls_e, 3'(cur_e), 1'b1, fin && f < 0,
                                     fin && f >= 0, 1'b0, cnt_e));
      if (n == rst_at) begin
        #1 rst_n = 1'b0;
        #1 check_eq("async_reset", obs(1), pack(1'b0, '0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, '0));
        cnt_m = '0;
        bus.layer_done = '0;
        #1 rst_n = 1'b1;
        return;
      end
      for (int i = 0; i < LAYERS; i++) begin
        if (i <= last && n >= st[i] + 1 && n <= we[i]) dn[i] = (i != f) && (n == we[i]);
        else dn[i] = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      bus.layer_done = dn;
      if (n == rel) begin
        if (f < 0) bus.result_ready = 1'b1;
        else bus.clear_err = 1'b1;
        bus.start_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      end else if (fin) begin
        // Wrong-state stimulus while holding the result or the error.
        bus.start_valid = 1'($urandom_range(0, 1));
        if (f < 0) bus.clear_err = 1'($urandom_range(0, 1));
        else bus.result_ready = 1'($urandom_range(0, 1));
      end else if (noise) begin
        bus.start_valid  = 1'($urandom_range(0, 1));
        bus.clear_err    = 1'($urandom_range(0, 1));
        bus.result_ready = 1'($urandom_range(0, 1));
      end
    end
  endtask

  initial begin
    int d[LAYERS];
    bus.start_valid  = 1'b0;
    bus.layer_done   = '0;
    bus.result_ready = 1'b0;
    bus.clear_err    = 1'b0;
    cnt_m = '0;
    #12;
    check_eq("reset", obs(1), pack(1'b0, '0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, '0));
    @(negedge clk);
    rst_n = 1'b1;

    d = '{4, 4, 4};
    run_sample(d, 1'b0, 10, 0);
    check_eq("count_one", 32'(bus.sample_count), 32'd1);

    d = '{5, 3, 2};
    run_sample(d, 1'b1, 2, 0);

    d = '{2, TIMEOUT + 5, 1};
    run_sample(d, 1'b0, 4, 0);

    d = '{TIMEOUT, 1, TIMEOUT + 1};
    run_sample(d, 1'b1, 3, 0);

    d = '{1, 1, TIMEOUT};
    run_sample(d, 1'b1, 0, 0);

    d = '{2, 6, 2};
    run_sample(d, 1'b0, 0, 8);

    for (int k = 0; k < 256; k++) begin
      for (int i = 0; i < LAYERS; i++) d[i] = int'($urandom_range(1, 3));
      run_sample(d, 1'($urandom_range(0, 1)), 0, 0);
    end
    check_eq("wrap", 32'(bus.sample_count), 32'd0);

    for (int k = 0; k < 30; k++) begin
      for (int i = 0; i < LAYERS; i++)
        d[i] = ($urandom_range(0, 9) == 0) ? int'($urandom_range(TIMEOUT - 1, TIMEOUT + 2))
                                            : int'($urandom_range(1, 6));
      run_sample(d, 1'($urandom_range(0, 1)), int'($urandom_range(0, 5)), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
